im_boot_loader: RTL and testbench

- Boot-time loader in front of the CPU's instruction-memory write port (im_write_enable / im_write_address / im_write_data).
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each assembled word to instruction memory at consecutive addresses.
- Holds the CPU in reset (cpu_reset_n) until the full image has been written, then releases it.

---
 rtl/im_boot_loader.sv | 160 ++++++++++++++++
 tb/tb_im_boot_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/im_boot_loader.sv
// Boot loader: turns a length-prefixed little-endian byte stream into consecutive
// instruction-memory writes and holds the CPU in reset until the image is in place.
module im_boot_loader #(
    parameter int                      DATA_SIZE    = 32,
    parameter int                      ADDRESS_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] BASE_ADDR    = '0,
    parameter logic [ADDRESS_SIZE-1:0] ADDR_STEP    = ADDRESS_SIZE'(4),
    parameter int                      MAX_WORDS    = 1024
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [7:0]              in_data,
    output logic                    in_ready,
    output logic                    im_write_enable,
    output logic [ADDRESS_SIZE-1:0] im_write_address,
    output logic [DATA_SIZE-1:0]    im_write_data,
    output logic                    cpu_reset_n,
    output logic                    load_done,
    output logic                    load_error,
    output logic [15:0]             words_written
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_WORD,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [15:0]             r_len;
    logic [1:0]              r_byte_cnt;
    logic [23:0]             r_word;
    logic [ADDRESS_SIZE-1:0] r_addr;
    logic [ADDRESS_SIZE-1:0] r_wr_addr;
    logic [DATA_SIZE-1:0]    r_wr_data;
    logic [15:0]             r_words;

    logic                    r_in_ready;
    logic                    r_we;
    logic                    r_cpu_rst_n;
    logic                    r_done;
    logic                    r_err;

    logic                    w_xfer;
    logic                    w_start_ok;
    logic [15:0]             w_len_full;

    assign w_xfer     = in_valid && r_in_ready;
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                  (r_state == S_ERROR));
    assign w_len_full = {in_data, r_len[7:0]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) w_state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_xfer) w_state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_xfer) begin
                    if (w_len_full == 16'd0)       w_state_nxt = S_DONE;
                    else if (w_len_full > MAX_LEN) w_state_nxt = S_ERROR;
                    else                           w_state_nxt = S_WORD;
                end
            end
            S_WORD: begin
                if (w_xfer && (r_byte_cnt == 2'd3)) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (r_words + 16'd1 == r_len) w_state_nxt = S_DONE;
                else                          w_state_nxt = S_WORD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_addr     <= BASE_ADDR;
            r_wr_addr  <= BASE_ADDR;
            r_wr_data  <= '0;
            r_words    <= '0;
        end else begin
            if (w_start_ok) begin
                r_words    <= '0;
                r_addr     <= BASE_ADDR;
                r_byte_cnt <= '0;
            end
            if (w_xfer && (r_state == S_LEN_LO)) r_len[7:0]  <= in_data;
            if (w_xfer && (r_state == S_LEN_HI)) r_len[15:8] <= in_data;
            if (w_xfer && (r_state == S_WORD)) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0: r_word[7:0]   <= in_data;
                    2'd1: r_word[15:8]  <= in_data;
                    2'd2: r_word[23:16] <= in_data;
                    default: begin
                        // Last byte goes straight into the write port so the strobe
                        // cycle already carries the full word.
                        r_wr_data <= {in_data, r_word};
                        r_wr_addr <= r_addr;
                    end
                endcase
            end
            if (r_state == S_WRITE) begin
                r_addr  <= r_addr + ADDR_STEP;
                r_words <= r_words + 16'd1;
            end
        end
    end

    // Status outputs are registered from the next state so they never glitch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_in_ready  <= 1'b0;
            r_we        <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_LEN_LO) || (w_state_nxt == S_LEN_HI) ||
                           (w_state_nxt == S_WORD);
            r_we        <= (w_state_nxt == S_WRITE);
            r_cpu_rst_n <= (w_state_nxt == S_DONE);
            r_done      <= (w_state_nxt == S_DONE);
            r_err       <= (w_state_nxt == S_ERROR);
        end
    end

    assign in_ready         = r_in_ready;
    assign im_write_enable  = r_we;
    assign im_write_address = r_wr_addr;
    assign im_write_data    = r_wr_data;
    assign cpu_reset_n      = r_cpu_rst_n;
    assign load_done        = r_done;
    assign load_error       = r_err;
    assign words_written    = r_words;

endmodule

// File: tb/tb_im_boot_loader.sv
// Randomized bench for im_boot_loader: expected writes come from the image itself
// (word i -> BASE + 4*i), checked on every strobe and around every load.
module tb_im_boot_loader;

    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] STEP = 32'h4;
    localparam int          MAXW = 1024;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h0;
    logic        in_ready;
    logic        im_write_enable;
    logic [31:0] im_write_address;
    logic [31:0] im_write_data;
    logic        cpu_reset_n;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_written;

    im_boot_loader dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .im_write_enable  (im_write_enable),
        .im_write_address (im_write_address),
        .im_write_data    (im_write_data),
        .cpu_reset_n      (cpu_reset_n),
        .load_done        (load_done),
        .load_error       (load_error),
        .words_written    (words_written)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] img[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle checker: strobes against the expected-write queue, hold behaviour otherwise.
    logic [31:0] prev_a, prev_d;
    bit          hold_ok = 1'b0;
    always @(negedge clock) begin
        if (!reset_n) begin
            hold_ok = 1'b0;
        end else begin
            chk("cpu_rst_vs_done", {31'b0, cpu_reset_n}, {31'b0, load_done});
            chk("done_err_excl", {31'b0, load_done & load_error}, 32'd0);
            if (im_write_enable) begin
                chk("ready_in_write", {31'b0, in_ready}, 32'd0);
                if (exp_addr.size() == 0) begin
                    chk("unexpected_write", {31'b0, im_write_enable}, 32'd0);
                end else begin
                    chk("wr_addr", im_write_address, exp_addr.pop_front());
                    chk("wr_data", im_write_data, exp_data.pop_front());
                end
                last_addr = im_write_address;
                last_data = im_write_data;
            end else if (hold_ok) begin
                chk("hold_addr", im_write_address, prev_a);
                chk("hold_data", im_write_data, prev_d);
            end
            prev_a  = im_write_address;
            prev_d  = im_write_data;
            hold_ok = 1'b1;
        end
    end

    task automatic fill(input int n);
        img.delete();
        repeat (n) img.push_back($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gate, input bit with_start,
                             output int tries);
        bit ok;
        ok    = 1'b0;
        tries = 0;
        while (!ok && tries < 100) begin
            @(negedge clock);
            in_data  = b;
            in_valid = gate ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = with_start && (tries == 0);
            ok       = in_valid && in_ready;
            tries++;
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
        if (!ok) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic load(input int n, input bit gate, input bit mid_start);
        int          tries;
        logic [15:0] n16;
        logic [31:0] wd;
        bit          err;
        n16 = n[15:0];
        err = (n > MAXW);
        pulse_start();
        @(negedge clock);
        chk("start_ready", {31'b0, in_ready}, 32'd1);
        chk("start_cpu_rst", {31'b0, cpu_reset_n}, 32'd0);
        chk("start_done", {31'b0, load_done}, 32'd0);
        chk("start_err", {31'b0, load_error}, 32'd0);
        chk("start_words", {16'b0, words_written}, 32'd0);
        send_byte(n16[7:0], gate, 1'b0, tries);
        if (!gate) chk("len_lo_stall", tries, 1);
        send_byte(n16[15:8], gate, 1'b0, tries);
        if (!gate) chk("len_hi_stall", tries, 1);
        if (err || n == 0) begin
            @(negedge clock);
            chk("len_done", {31'b0, load_done}, {31'b0, !err});
            chk("len_err", {31'b0, load_error}, {31'b0, err});
            chk("len_cpu", {31'b0, cpu_reset_n}, {31'b0, !err});
            chk("len_ready", {31'b0, in_ready}, 32'd0);
            chk("len_words", {16'b0, words_written}, 32'd0);
            return;
        end
        for (int w = 0; w < n; w++) begin
            wd = img[w];
            for (int k = 0; k < 4; k++) begin
                send_byte(wd[8*k +: 8], gate, mid_start && w == 0 && k == 1, tries);
                if (!gate) chk("byte_stall", tries, 1);
            end
            exp_addr.push_back(BASE + STEP * 32'(w));
            exp_data.push_back(wd);
            @(negedge clock);
            chk("wr_latency", {31'b0, im_write_enable}, 32'd1);
            chk("wr_count", {16'b0, words_written}, 32'(w));
        end
        @(negedge clock);
        chk("end_done", {31'b0, load_done}, 32'd1);
        chk("end_cpu", {31'b0, cpu_reset_n}, 32'd1);
        chk("end_words", {16'b0, words_written}, 32'(n));
        chk("end_ready", {31'b0, in_ready}, 32'd0);
        chk("end_pending", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_we"}, {31'b0, im_write_enable}, 32'd0);
        chk({tag, "_addr"}, im_write_address, BASE);
        chk({tag, "_data"}, im_write_data, 32'd0);
        chk({tag, "_cpu"}, {31'b0, cpu_reset_n}, 32'd0);
        chk({tag, "_done"}, {31'b0, load_done}, 32'd0);
        chk({tag, "_err"}, {31'b0, load_error}, 32'd0);
        chk({tag, "_words"}, {16'b0, words_written}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int tries;
        #1;
        chk_reset_outputs("rst");
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // Two-word reference image with hand-computed results.
        img = '{32'h20000013, 32'hAC000008};
        load(2, 1'b0, 1'b0);
        chk("t1_last_addr", last_addr, 32'h4);
        chk("t1_last_data", last_data, 32'hAC000008);

        load(0, 1'b0, 1'b0);

        load(1025, 1'b0, 1'b0);
        fill(1);
        load(1, 1'b0, 1'b0);

        fill(3);
        load(3, 1'b1, 1'b0);

        // Abandon a load part-way through its first word.
        pulse_start();
        send_byte(8'd3, 1'b0, 1'b0, tries);
        send_byte(8'd0, 1'b0, 1'b0, tries);
        send_byte(8'h11, 1'b0, 1'b0, tries);
        send_byte(8'h22, 1'b0, 1'b0, tries);
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(posedge clock);
        #1 reset_n = 1'b1;
        fill(3);
        load(3, 1'b0, 1'b0);

        fill(4);
        load(4, 1'b1, 1'b1);
        fill(2);
        load(2, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            fill(int'($urandom_range(1, 8)));
            load(img.size(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        fill(MAXW);
        load(MAXW, 1'b0, 1'b0);
        chk("max_last_addr", last_addr, BASE + STEP * 32'(MAXW - 1));

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
